// File: rtl/obi_data_if.sv
// OBI data-channel bundle: address phase (req/addr/we/be/wdata/gnt) plus response phase (rvalid/rdata).
// The master modport is the side that issues requests; the slave modport is the side that grants them.
interface obi_data_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  // Handshake: an address phase transfers in the cycle where req && gnt are both high.
  // Once req is raised it is held, with stable addr/we/be/wdata, until gnt.
  // Each transfer later gets exactly one rvalid, and responses come back in request order.
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_data_arbiter.sv
// 2:1 round-robin arbiter in front of one OBI data port, with address-phase locking and an owner FIFO
// so that every response is routed back to the master that issued the request.
module obi_data_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  obi_data_if.slave                              m0,
  obi_data_if.slave                              m1,
  obi_data_if.master                             data,
  output logic                                   busy_o,
  output logic                                   rsp_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   dbg_cnt_o
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  logic                       sel_q, lock_q, last_q;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              cnt_q;

  logic sel, sel_req, full, grant, rsp_ok, head;

  // A locked address phase keeps its owner; otherwise a lone requester wins and a tie alternates.
  always_comb begin
    sel = ~last_q;
    if (lock_q)                 sel = sel_q;
    else if (m0.req && !m1.req) sel = 1'b0;
    else if (m1.req && !m0.req) sel = 1'b1;
  end

  assign full    = (cnt_q == CNT_FULL);
  assign sel_req = sel ? m1.req : m0.req;
  assign grant   = data.req && data.gnt;
  assign head    = owner_q[rd_ptr_q];
  assign rsp_ok  = rst_n && data.rvalid && (cnt_q != '0);

  assign data.req   = rst_n && sel_req && !full;
  assign data.addr  = rst_n ? (sel ? m1.addr  : m0.addr)  : '0;
  assign data.we    = rst_n && (sel ? m1.we : m0.we);
  assign data.be    = rst_n ? (sel ? m1.be    : m0.be)    : '0;
  assign data.wdata = rst_n ? (sel ? m1.wdata : m0.wdata) : '0;

  assign m0.gnt    = grant && !sel;
  assign m1.gnt    = grant && sel;
  assign m0.rvalid = rsp_ok && !head;
  assign m1.rvalid = rsp_ok && head;
  assign m0.rdata  = rst_n ? data.rdata : '0;
  assign m1.rdata  = rst_n ? data.rdata : '0;

  assign busy_o    = rst_n && (cnt_q != '0);
  assign rsp_err_o = rst_n && data.rvalid && (cnt_q == '0);
  assign dbg_cnt_o = rst_n ? cnt_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q    <= 1'b0;
      lock_q   <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (data.req && !data.gnt) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (grant) begin
        lock_q            <= 1'b0;
        last_q            <= sel;
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rsp_ok) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({grant, rsp_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_obi_data_arbiter.sv
// Bench for obi_data_arbiter: directed scenarios followed by a randomized run, every cycle compared
// against a queue-based reference model of ownership, locking and round-robin fairness.
module tb_obi_data_arbiter;
  localparam int unsigned MAX = 2;

  logic clk;
  logic rst_n;
  logic busy_o, rsp_err_o;
  logic [$clog2(MAX+1)-1:0] dbg_cnt_o;

  obi_data_if m0_bus ();
  obi_data_if m1_bus ();
  obi_data_if data_bus ();

  obi_data_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .data      (data_bus),
    .busy_o    (busy_o),
    .rsp_err_o (rsp_err_o),
    .dbg_cnt_o (dbg_cnt_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit mdl_lock;
  bit mdl_sel_q;
  bit mdl_last;
  bit own_q[$];
  bit e_sel, e_req, e_gnt, e_rv;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_lock  = 1'b0;
    mdl_sel_q = 1'b0;
    mdl_last  = 1'b1;
    own_q.delete();
  endtask

  // driver tasks
  task automatic drive(bit rst, bit r0, bit r1, bit g, bit rv);
    rst_n           = rst;
    m0_bus.req      = r0;
    m1_bus.req      = r1;
    data_bus.gnt    = g;
    data_bus.rvalid = rv;
    data_bus.rdata  = $urandom;
  endtask

  task automatic rand_payload();
    m0_bus.addr  = {4'h1, 28'($urandom)};
    m0_bus.we    = 1'($urandom_range(0, 1));
    m0_bus.be    = 4'($urandom);
    m0_bus.wdata = $urandom;
    m1_bus.addr  = {4'h2, 28'($urandom)};
    m1_bus.we    = 1'($urandom_range(0, 1));
    m1_bus.be    = 4'($urandom);
    m1_bus.wdata = $urandom;
  endtask

  // Let the combinational outputs settle, then compare everything against the model.
  task automatic settle();
    bit e_head, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic        e_we;
    #1;
    if (mdl_lock)                          e_sel = mdl_sel_q;
    else if (m0_bus.req != m1_bus.req)     e_sel = m1_bus.req;
    else                                   e_sel = !mdl_last;
    e_req  = rst_n && (e_sel ? m1_bus.req : m0_bus.req) && (own_q.size() < MAX);
    e_gnt  = e_req && data_bus.gnt;
    e_rv   = rst_n && data_bus.rvalid && (own_q.size() > 0);
    e_head = (own_q.size() > 0) ? own_q[0] : 1'b0;
    e_err  = rst_n && data_bus.rvalid && (own_q.size() == 0);
    e_addr  = rst_n ? (e_sel ? m1_bus.addr  : m0_bus.addr)  : 32'h0;
    e_wdata = rst_n ? (e_sel ? m1_bus.wdata : m0_bus.wdata) : 32'h0;
    e_be    = rst_n ? (e_sel ? m1_bus.be    : m0_bus.be)    : 4'h0;
    e_we    = rst_n && (e_sel ? m1_bus.we : m0_bus.we);
    e_rdata = rst_n ? data_bus.rdata : 32'h0;
    check("data_req",  32'(data_bus.req),   32'(e_req));
    check("data_addr", data_bus.addr,       e_addr);
    check("data_we",   32'(data_bus.we),    32'(e_we));
    check("data_be",   32'(data_bus.be),    32'(e_be));
    check("data_wdata", data_bus.wdata,     e_wdata);
    check("m0_gnt",    32'(m0_bus.gnt),     32'(e_gnt && !e_sel));
    check("m1_gnt",    32'(m1_bus.gnt),     32'(e_gnt && e_sel));
    check("m0_rvalid", 32'(m0_bus.rvalid),  32'(e_rv && !e_head));
    check("m1_rvalid", 32'(m1_bus.rvalid),  32'(e_rv && e_head));
    check("m0_rdata",  m0_bus.rdata,        e_rdata);
    check("m1_rdata",  m1_bus.rdata,        e_rdata);
    check("busy",      32'(busy_o),         32'(rst_n && own_q.size() != 0));
    check("rsp_err",   32'(rsp_err_o),      32'(e_err));
    check("dbg_cnt",   32'(dbg_cnt_o),      rst_n ? 32'(own_q.size()) : 32'h0);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      mdl_reset();
    end else begin
      if (e_rv) void'(own_q.pop_front());
      if (e_req && !data_bus.gnt) begin
        mdl_lock  = 1'b1;
        mdl_sel_q = e_sel;
      end
      if (e_gnt) begin
        mdl_lock = 1'b0;
        own_q.push_back(e_sel);
        mdl_last = e_sel;
      end
    end
    @(negedge clk);
  endtask

  logic [31:0] a1;

  initial begin
    mdl_reset();
    rand_payload();
    drive(0, 0, 0, 0, 0);
    settle(); advance();
    drive(0, 1, 1, 1, 1);
    settle();
    check("reset_req", 32'(data_bus.req), 32'h0);
    advance();

    // Both masters always request, bus grants every cycle, response one cycle later.
    for (int k = 0; k < 6; k++) begin
      rand_payload();
      drive(1, 1, 1, 1, k > 0);
      settle();
      check("t1_m0_gnt",    32'(m0_bus.gnt),    32'(k % 2 == 0));
      check("t1_m1_gnt",    32'(m1_bus.gnt),    32'(k % 2 == 1));
      check("t1_m0_rvalid", 32'(m0_bus.rvalid), 32'(k > 0 && k % 2 == 1));
      check("t1_m1_rvalid", 32'(m1_bus.rvalid), 32'(k > 0 && k % 2 == 0));
      advance();
      check("t1_cnt", 32'(dbg_cnt_o), 32'h1);
    end
    drive(1, 0, 0, 1, 1);
    settle();
    check("t1_last_rsp", 32'(m1_bus.rvalid), 32'h1);
    advance();

    // m1 holds an unanswered request; m0 joins but must wait for the lock to release.
    rand_payload();
    a1 = m1_bus.addr;
    for (int k = 0; k < 3; k++) begin
      drive(1, k > 0, 1, 0, 0);
      settle();
      check("t2_locked_addr", data_bus.addr, a1);
      advance();
    end
    drive(1, 1, 1, 1, 0);
    settle();
    check("t2_m1_gnt", 32'(m1_bus.gnt), 32'h1);
    advance();
    drive(1, 1, 0, 1, 0);
    settle();
    check("t2_m0_gnt", 32'(m0_bus.gnt), 32'h1);
    advance();

    // Two outstanding: full until a response frees a slot, then grant next cycle.
    drive(1, 1, 1, 1, 0);
    settle();
    check("t3_full_req",  32'(data_bus.req), 32'h0);
    check("t3_full_busy", 32'(busy_o),       32'h1);
    advance();
    drive(1, 1, 0, 1, 1);
    settle();
    check("t3_free_req",  32'(data_bus.req),   32'h0);
    check("t3_free_rsp",  32'(m1_bus.rvalid),  32'h1);
    advance();
    drive(1, 1, 0, 1, 0);
    settle();
    check("t3_regrant", 32'(m0_bus.gnt), 32'h1);
    advance();

    // Reset with two outstanding; a late response is then unexpected.
    drive(0, 0, 0, 0, 0);
    settle(); advance();
    drive(1, 0, 0, 0, 1);
    settle();
    check("t6_busy",    32'(busy_o),          32'h0);
    check("t5_err",     32'(rsp_err_o),       32'h1);
    check("t5_rv0",     32'(m0_bus.rvalid),   32'h0);
    check("t5_rv1",     32'(m1_bus.rvalid),   32'h0);
    advance();
    drive(1, 0, 0, 0, 0);
    settle();
    check("t5_err_pulse", 32'(rsp_err_o), 32'h0);
    advance();
    drive(1, 1, 1, 1, 0);
    settle();
    check("t6_first_m0", 32'(m0_bus.gnt), 32'h1);
    advance();

    // Randomized traffic, including stray responses and occasional resets.
    for (int k = 0; k < 600; k++) begin
      rand_payload();
      drive($urandom_range(0, 63) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
